// File: rtl/w5300_bus_engine.sv
// w5300_bus_engine: host-side bus master for the Wiznet W5300 in direct 16-bit mode.
// Turns single/burst register requests into timed nCS/nRD/nWR cycles, resolves
// socket register addresses and holds the address for Sn_TX/RX_FIFOR bursts.
// Optional request checking: define W5300_REQ_CHECK_EN to reject malformed
// requests (odd address, socket out of range, socket offset out of window).
module w5300_bus_engine #(
   parameter int unsigned SOCKETS  = 2,
   parameter int unsigned T_SETUP  = 1,
   parameter int unsigned T_STROBE = 7,
   parameter int unsigned T_HOLD   = 2,
   parameter int unsigned LEN_W    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_op,
   input  logic [2:0]       req_sock,
   input  logic             req_sock_reg,
   input  logic [9:0]       req_addr,
   input  logic [LEN_W-1:0] req_len,
   input  logic [15:0]      wdata,
   input  logic             wdata_valid,
   output logic             wdata_ready,
   output logic [15:0]      rdata,
   output logic             rdata_valid,
   output logic             done,
   output logic             err,
   output logic [9:0]       bus_addr,
   output logic             bus_cs_n,
   output logic             bus_rd_n,
   output logic             bus_wr_n,
   output logic [15:0]      bus_dout,
   output logic             bus_doe,
   input  logic [15:0]      bus_din
);

   localparam int unsigned T_MAX = (T_SETUP > T_STROBE) ?
                                   ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD) :
                                   ((T_STROBE > T_HOLD) ? T_STROBE : T_HOLD);
   localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(T_STROBE - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(T_HOLD - 1);

   localparam logic [9:0] SOCK_LO = 10'h200;
   localparam logic [9:0] SOCK_HI = 10'h23E;
   localparam logic [9:0] TX_FIFO = 10'h22E;
   localparam logic [9:0] RX_FIFO = 10'h230;

`ifdef W5300_REQ_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] wcnt_q, wcnt_d;
   logic [9:0]       addr_q, addr_d;
   logic             op_rd_q, op_rd_d;
   logic             fifo_q, fifo_d;
   logic             held_q, held_d;
   logic [15:0]      dout_q, dout_d;
   logic [15:0]      rdata_q, rdata_d;
   logic             rdv_q, rdv_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             cs_n_q, cs_n_d;
   logic             rd_n_q, rd_n_d;
   logic             wr_n_q, wr_n_d;

   logic [9:0]       ea;
   logic             is_fifo;
   logic             bad_req;
   logic             reject;
   logic             setup_go;
   logic             take;

   // Effective address of the incoming request (socket offset folded in)
   always_comb begin
      ea = req_addr;
      if (req_sock_reg) ea = req_addr + (10'(req_sock) << 6);
   end

   assign is_fifo  = req_sock_reg && ((req_addr == TX_FIFO) || (req_addr == RX_FIFO));
   assign bad_req  = req_addr[0] ||
                     (req_sock_reg && ((32'(req_sock) >= SOCKETS) ||
                                       (req_addr < SOCK_LO) || (req_addr > SOCK_HI)));
   assign reject   = CHECK_EN && bad_req;
   // Reads count setup immediately; writes only once a data word is on the bus
   assign setup_go = op_rd_q || held_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (req_valid && !reject) state_d = S_SETUP;
         S_SETUP:  if (setup_go && (cnt_q == SETUP_LAST)) state_d = S_STROBE;
         S_STROBE: if (cnt_q == STROBE_LAST) state_d = S_HOLD;
         S_HOLD:   if (cnt_q == HOLD_LAST) state_d = (wcnt_q != '0) ? S_SETUP : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values; strobes decode the next state so they leave a flop
   always_comb begin
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      op_rd_d = op_rd_q;
      fifo_d  = fifo_q;
      held_d  = held_q;
      dout_d  = dout_q;
      rdata_d = rdata_q;
      rdv_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      take    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (reject) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  op_rd_d = req_op;
                  fifo_d  = is_fifo;
                  addr_d  = ea;
                  wcnt_d  = req_len;
                  cnt_d   = '0;
                  take    = !req_op;
               end
            end
         end
         S_SETUP: begin
            if (setup_go) cnt_d = (cnt_q == SETUP_LAST) ? '0 : cnt_q + CNT_W'(1);
            else          take  = 1'b1;
         end
         S_STROBE: begin
            cnt_d = (cnt_q == STROBE_LAST) ? '0 : cnt_q + CNT_W'(1);
            if ((cnt_q == STROBE_LAST) && op_rd_q) begin
               rdata_d = bus_din;
               rdv_d   = 1'b1;
            end
         end
         S_HOLD: begin
            cnt_d = (cnt_q == HOLD_LAST) ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == HOLD_LAST) begin
               held_d = 1'b0;
               if (wcnt_q != '0) begin
                  wcnt_d = wcnt_q - LEN_W'(1);
                  if (!fifo_q) addr_d = addr_q + 10'd2;
                  take = !op_rd_q;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
      if (take && wdata_valid) begin
         held_d = 1'b1;
         dout_d = wdata;
      end
      cs_n_d = !((state_d == S_SETUP) || (state_d == S_STROBE));
      rd_n_d = !((state_d == S_STROBE) && op_rd_d);
      wr_n_d = !((state_d == S_STROBE) && !op_rd_d);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         wcnt_q  <= '0;
         addr_q  <= '0;
         op_rd_q <= 1'b0;
         fifo_q  <= 1'b0;
         held_q  <= 1'b0;
         dout_q  <= '0;
         rdata_q <= '0;
         rdv_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         rd_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         op_rd_q <= op_rd_d;
         fifo_q  <= fifo_d;
         held_q  <= held_d;
         dout_q  <= dout_d;
         rdata_q <= rdata_d;
         rdv_q   <= rdv_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cs_n_q  <= cs_n_d;
         rd_n_q  <= rd_n_d;
         wr_n_q  <= wr_n_d;
      end
   end

   assign req_ready   = (state_q == S_IDLE) && !rst;
   assign wdata_ready = take && wdata_valid && !rst;
   assign rdata       = rdata_q;
   assign rdata_valid = rdv_q;
   assign done        = done_q;
   assign err         = err_q;
   assign bus_addr    = addr_q;
   assign bus_cs_n    = cs_n_q;
   assign bus_rd_n    = rd_n_q;
   assign bus_wr_n    = wr_n_q;
   assign bus_dout    = dout_q;
   assign bus_doe     = held_q;

endmodule

// File: tb/tb_w5300_bus_engine.sv
// tb_w5300_bus_engine: randomized and directed bench for w5300_bus_engine with a
// timeline model of each request (per-word setup/strobe/hold windows).
module tb_w5300_bus_engine;

   localparam int unsigned SOCKETS = 2;
   localparam int unsigned TS      = 1;
   localparam int unsigned TST     = 7;
   localparam int unsigned TH      = 2;
   localparam int unsigned LEN_W   = 10;
   localparam int          WT      = TS + TST + TH;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_op = 1'b0;
   logic [2:0]       req_sock = '0;
   logic             req_sock_reg = 1'b0;
   logic [9:0]       req_addr = '0;
   logic [LEN_W-1:0] req_len = '0;
   logic [15:0]      wdata = '0;
   logic             wdata_valid = 1'b0;
   logic [15:0]      bus_din = '0;
   logic             req_ready, wdata_ready, rdata_valid, done, err;
   logic [15:0]      rdata, bus_dout;
   logic [9:0]       bus_addr;
   logic             bus_cs_n, bus_rd_n, bus_wr_n, bus_doe;

   always #5 clk = ~clk;

   w5300_bus_engine #(
      .SOCKETS(SOCKETS), .T_SETUP(TS), .T_STROBE(TST), .T_HOLD(TH), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_sock(req_sock), .req_sock_reg(req_sock_reg),
      .req_addr(req_addr), .req_len(req_len), .wdata(wdata),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .rdata(rdata),
      .rdata_valid(rdata_valid), .done(done), .err(err), .bus_addr(bus_addr),
      .bus_cs_n(bus_cs_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
      .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_din(bus_din)
   );

   int total = 0;
   int bad   = 0;

   // Per-request schedule: c_t[i] is the cycle in which word i's data is taken
   int          c_t[16];
   int          gap_w[16];
   logic [15:0] wd[16];
   logic [15:0] din[16];

   int          obs_done_t, obs_rdv_t, cs_first, cs_last, wr_first, wr_last;
   int          doe_first, doe_last, n_pulse, n_wait;
   logic [15:0] obs_rdata;
   logic [9:0]  obs_paddr[16];
   logic [15:0] obs_pdata[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=0x%0h exp=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive_data(input logic op_rd, input int n, input int t);
      wdata_valid = 1'b0;
      wdata       = 16'($urandom);
      bus_din     = 16'($urandom);
      for (int i = 0; i < n; i++) begin
         if (!op_rd && c_t[i] == t) begin
            wdata_valid = 1'b1;
            wdata       = wd[i];
         end
         if (op_rd && (c_t[i] + TS + TST) == t) bus_din = din[i];
      end
   endtask

   function automatic logic exp_wrdy(input logic op_rd, input int n, input int t);
      logic r;
      r = 1'b0;
      for (int i = 0; i < n; i++) if (!op_rd && c_t[i] == t) r = 1'b1;
      return r;
   endfunction

   // Run one request starting in the current cycle; stop_t > 0 truncates it
   task automatic run_txn(input logic op_rd, input logic [2:0] sock, input logic sreg,
                          input logic [9:0] addr, input int len, input int stop_t);
      int n, o, done_t, t_end;
      logic fifo, prev_strb;
      logic [9:0] ea;
      logic e_cs, e_rd, e_wr, e_doe, e_rdv, in_word;
      logic [9:0] e_addr;
      logic [15:0] e_dout, e_rdata;
      n    = len + 1;
      fifo = sreg && (addr == 10'h22E || addr == 10'h230);
      ea   = sreg ? 10'(addr + {sock, 6'b0}) : addr;
      o    = 0;
      for (int i = 0; i < n; i++) begin
         c_t[i] = op_rd ? o : o + gap_w[i];
         o      = c_t[i] + WT;
      end
      done_t = o + 1;
      t_end  = (stop_t > 0 && stop_t < done_t) ? stop_t : done_t;
      obs_done_t = -1; obs_rdv_t = -1; cs_first = -1; cs_last = -1;
      wr_first = -1; wr_last = -1; doe_first = -1; doe_last = -1;
      n_pulse = 0; n_wait = 0; obs_rdata = '0; prev_strb = 1'b0;
      chk("ready_at_accept", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = op_rd; req_sock = sock; req_sock_reg = sreg;
      req_addr = addr; req_len = LEN_W'(len);
      drive_data(op_rd, n, 0);
      #1 chk("wdata_ready", 32'(wdata_ready), 32'(exp_wrdy(op_rd, n, 0)));
      for (int t = 1; t <= t_end; t++) begin
         @(posedge clk); #1;
         e_cs = 1; e_rd = 1; e_wr = 1; e_doe = 0; e_rdv = 0; in_word = 0;
         e_addr = '0; e_dout = '0; e_rdata = '0;
         for (int i = 0; i < n; i++) begin
            int oi;
            oi = (i == 0) ? 0 : c_t[i-1] + WT;
            if (t > oi && t <= c_t[i] + WT) begin
               in_word = 1;
               e_addr  = 10'(ea + (fifo ? 0 : 2 * i));
               if (t <= c_t[i] + TS + TST) e_cs = 0;
               if (t > c_t[i] + TS && t <= c_t[i] + TS + TST) begin
                  if (op_rd) e_rd = 0; else e_wr = 0;
               end
               if (!op_rd && t > c_t[i]) begin e_doe = 1; e_dout = wd[i]; end
               if (op_rd && t == c_t[i] + TS + TST + 1) begin e_rdv = 1; e_rdata = din[i]; end
            end
         end
         chk("bus_cs_n", 32'(bus_cs_n), 32'(e_cs));
         chk("bus_rd_n", 32'(bus_rd_n), 32'(e_rd));
         chk("bus_wr_n", 32'(bus_wr_n), 32'(e_wr));
         chk("bus_doe", 32'(bus_doe), 32'(e_doe));
         chk("rdata_valid", 32'(rdata_valid), 32'(e_rdv));
         chk("done", 32'(done), 32'(t == done_t));
         chk("req_ready", 32'(req_ready), 32'(t == done_t));
         chk("err", 32'(err), 32'd0);
         if (in_word) chk("bus_addr", 32'(bus_addr), 32'(e_addr));
         if (e_doe)   chk("bus_dout", 32'(bus_dout), 32'(e_dout));
         if (e_rdv)   chk("rdata", 32'(rdata), 32'(e_rdata));
         if (done && obs_done_t < 0) obs_done_t = t;
         if (rdata_valid) begin
            if (obs_rdv_t < 0) obs_rdv_t = t;
            obs_rdata = rdata;
         end
         if (!bus_cs_n) begin if (cs_first < 0) cs_first = t; cs_last = t; end
         if (!bus_wr_n) begin if (wr_first < 0) wr_first = t; wr_last = t; end
         if (bus_doe)   begin if (doe_first < 0) doe_first = t; doe_last = t; end
         if (!op_rd && !bus_cs_n && bus_wr_n && !bus_doe) n_wait++;
         if ((!bus_wr_n || !bus_rd_n) && !prev_strb && n_pulse < 16) begin
            obs_paddr[n_pulse] = bus_addr;
            obs_pdata[n_pulse] = bus_dout;
            n_pulse++;
         end
         prev_strb = !bus_wr_n || !bus_rd_n;
         req_valid = 1'b0;
         drive_data(op_rd, n, t);
         #1 chk("wdata_ready", 32'(wdata_ready), 32'(exp_wrdy(op_rd, n, t)));
      end
   endtask

   task automatic step_idle();
      @(posedge clk); #1;
      wdata_valid = 1'b0;
      chk("idle_cs_n", 32'(bus_cs_n), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic set_req_data(input int n, input logic [15:0] base);
      for (int i = 0; i < 16; i++) begin
         gap_w[i] = 0;
         wd[i]    = 16'(base * 16'(i + 1));
         din[i]   = 16'($urandom);
      end
      if (n < 0) gap_w[0] = 0;
   endtask

`ifdef W5300_REQ_CHECK_EN
   task automatic run_reject(input logic [2:0] sock, input logic sreg, input logic [9:0] addr);
      chk("rej_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = 1'b0; req_sock = sock; req_sock_reg = sreg;
      req_addr = addr; req_len = '0; wdata_valid = 1'b1;
      #1 chk("rej_wdata_ready", 32'(wdata_ready), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0; wdata_valid = 1'b0;
      chk("rej_done", 32'(done), 32'd1);
      chk("rej_err", 32'(err), 32'd1);
      chk("rej_cs_n", 32'(bus_cs_n), 32'd1);
      @(posedge clk); #1;
      chk("rej_done_clear", 32'(done), 32'd0);
      chk("rej_cs_n2", 32'(bus_cs_n), 32'd1);
   endtask
`endif

   initial begin
      logic op, sreg;
      logic [2:0] sock;
      logic [9:0] addr;
      int len;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_cs_n", 32'(bus_cs_n), 32'd1);
      chk("rst_rd_n", 32'(bus_rd_n), 32'd1);
      chk("rst_wr_n", 32'(bus_wr_n), 32'd1);
      chk("rst_doe", 32'(bus_doe), 32'd0);
      chk("rst_addr", 32'(bus_addr), 32'd0);
      chk("rst_dout", 32'(bus_dout), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_rdv", 32'(rdata_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_wrdy", 32'(wdata_ready), 32'd0);
      rst = 1'b0;
      step_idle();

      // MR write 0xB800
      set_req_data(0, 16'h0);
      wd[0] = 16'hB800;
      run_txn(1'b0, 3'd0, 1'b0, 10'h000, 0, 0);
      chk("mr_done_t", 32'(obs_done_t), 32'd11);
      chk("mr_cs_first", 32'(cs_first), 32'd1);
      chk("mr_cs_last", 32'(cs_last), 32'd8);
      chk("mr_wr_first", 32'(wr_first), 32'd2);
      chk("mr_wr_last", 32'(wr_last), 32'd8);
      chk("mr_doe_first", 32'(doe_first), 32'd1);
      chk("mr_doe_last", 32'(doe_last), 32'd10);
      chk("mr_addr", 32'(obs_paddr[0]), 32'h000);
      chk("mr_data", 32'(obs_pdata[0]), 32'hB800);

      // IDR read, accepted in the done cycle of the previous request
      set_req_data(0, 16'h0);
      din[0] = 16'h5300;
      run_txn(1'b1, 3'd0, 1'b0, 10'h0FE, 0, 0);
      chk("idr_rdata", 32'(obs_rdata), 32'h5300);
      chk("idr_rdv_t", 32'(obs_rdv_t), 32'd9);
      chk("idr_done_t", 32'(obs_done_t), 32'd11);
      step_idle();

      // Socket 3 Sn_SSR read
      set_req_data(0, 16'h0);
      run_txn(1'b1, 3'd3, 1'b1, 10'h208, 0, 0);
      chk("ssr_addr", 32'(obs_paddr[0]), 32'h2C8);
      step_idle();

      // Non-socket burst read
      set_req_data(0, 16'h0);
      run_txn(1'b1, 3'd0, 1'b0, 10'h008, 2, 0);
      chk("burst_a0", 32'(obs_paddr[0]), 32'h008);
      chk("burst_a1", 32'(obs_paddr[1]), 32'h00A);
      chk("burst_a2", 32'(obs_paddr[2]), 32'h00C);
      chk("burst_done_t", 32'(obs_done_t), 32'd31);

      // TX FIFO burst with a 5-cycle data stall before the third word
      set_req_data(0, 16'h1111);
      gap_w[2] = 5;
      run_txn(1'b0, 3'd1, 1'b1, 10'h22E, 3, 0);
      chk("fifo_pulses", 32'(n_pulse), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("fifo_addr", 32'(obs_paddr[i]), 32'h26E);
         chk("fifo_data", 32'(obs_pdata[i]), 32'(16'h1111 * 16'(i + 1)));
      end
      chk("fifo_wait", 32'(n_wait), 32'd5);
      chk("fifo_done_t", 32'(obs_done_t), 32'd46);
      step_idle();

      // Address wrap at the top of the register space
      set_req_data(0, 16'h0);
      run_txn(1'b1, 3'd0, 1'b0, 10'h3FC, 2, 0);
      chk("wrap_a1", 32'(obs_paddr[1]), 32'h3FE);
      chk("wrap_a2", 32'(obs_paddr[2]), 32'h000);
      step_idle();

      // Out-of-range socket / odd address
      set_req_data(0, 16'h0);
`ifdef W5300_REQ_CHECK_EN
      run_reject(3'd5, 1'b1, 10'h208);
      run_reject(3'd0, 1'b0, 10'h009);
`else
      run_txn(1'b1, 3'd5, 1'b1, 10'h208, 0, 0);
      chk("sock5_addr", 32'(obs_paddr[0]), 32'h348);
`endif
      step_idle();

      // Randomized requests
      for (int k = 0; k < 40; k++) begin
         op   = 1'($urandom_range(0, 1));
         sreg = 1'($urandom_range(0, 1));
         sock = 3'($urandom_range(0, SOCKETS - 1));
         if (sreg) begin
            if ($urandom_range(0, 3) == 0) addr = ($urandom_range(0, 1) == 0) ? 10'h22E : 10'h230;
            else addr = 10'(10'h200 + 2 * $urandom_range(0, 31));
         end else begin
            addr = 10'(2 * $urandom_range(0, 511));
         end
         len = int'($urandom_range(0, 4));
         for (int i = 0; i < 16; i++) begin
            gap_w[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 8))
                                                   : int'($urandom_range(0, 2));
            wd[i]  = 16'($urandom);
            din[i] = 16'($urandom);
         end
         run_txn(op, sock, sreg, addr, len, 0);
         repeat ($urandom_range(0, 2)) step_idle();
      end
      step_idle();

      // Reset during the strobe of the second word of a read burst
      set_req_data(0, 16'h0);
      run_txn(1'b1, 3'd0, 1'b0, 10'h010, 3, 14);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_cs_n", 32'(bus_cs_n), 32'd1);
      chk("mid_rst_rd_n", 32'(bus_rd_n), 32'd1);
      chk("mid_rst_wr_n", 32'(bus_wr_n), 32'd1);
      chk("mid_rst_doe", 32'(bus_doe), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      repeat (4) step_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/w5300_bus_engine.md
# w5300_bus_engine

Parametrised host-side bus master for the Wiznet W5300 in direct, 16-bit mode. It sits between the register-level control FSMs (init, socket open, send/receive) and the W5300 pins. It converts single or burst register requests into timed nCS/nRD/nWR cycles. It computes socket register addresses for a configurable socket count and holds the address constant for Sn_TX_FIFOR/Sn_RX_FIFOR bursts.

## Interface
Parameters:
- SOCKETS, 2, number of usable sockets (1..8)
- T_SETUP, 1, cycles of address/CS setup before strobe (>=1)
- T_STROBE, 7, cycles nRD/nWR held low (>=1; 7 at 100 MHz meets W5300 tRD/tWR)
- T_HOLD, 2, cycles of strobe/CS high after strobe (>=1)
- LEN_W, 10, width of burst length field

Ports:
- clk  in  1  single clock domain.
- rst  in  1  reset. Synchronous, active-high.
- req_valid  in  1  request strobe.
- req_ready  out  1  engine idle; a request is accepted when req_valid & req_ready.
- req_op  in  1  0 = WR, 1 = RD.
- req_sock  in  3  socket index, used only when req_sock_reg = 1.
- req_sock_reg  in  1  req_addr is a socket-0 register offset (0x200..0x23E).
- req_addr  in  10  register byte address (even).
- req_len  in  LEN_W  burst length minus 1, in words.
- wdata  in  16  write word.
- wdata_valid  in  1  wdata available.
- wdata_ready  out  1  wdata consumed this cycle.
- rdata  out  16  read word.
- rdata_valid  out  1  one-cycle pulse per read word.
- done  out  1  one-cycle pulse at end of request.
- err  out  1  qualifies done; request rejected.
- bus_addr  out  10  W5300 ADDR[9:0].
- bus_cs_n, bus_rd_n, bus_wr_n  out  1 each  active-low strobes.
- bus_dout  out  16  write data.
- bus_doe  out  1  tristate enable for DATA[15:0].
- bus_din  in  16  DATA[15:0] input.

## Operation
- Reset values: req_ready 0 while rst high and 1 thereafter in IDLE; bus_cs_n, bus_rd_n and bus_wr_n are 1; bus_doe 0; bus_addr, bus_dout and rdata are 0; rdata_valid, wdata_ready, done and err are 0.
- Effective address:
  - sock_reg = 1: ea = req_addr + (req_sock << 6), 10-bit.
  - sock_reg = 0: ea = req_addr; req_sock is ignored.
- Burst address rule:
  - If sock_reg = 1 and req_addr is 0x22E or 0x230 (FIFO), the address is held for every word.
  - Otherwise the address increments by 2 per word and wraps mod 1024.
- States:
  - IDLE -> SETUP on accept. The request is latched and word counter = req_len.
  - SETUP: bus_cs_n = 0, bus_addr = current address.
    - WR: while no word is held, wdata_ready = wdata_valid. The word is captured into bus_dout and bus_doe = 1. The setup counter does not advance until a word has been captured.
    - After T_SETUP counted cycles -> STROBE.
  - STROBE: bus_cs_n = 0 and bus_rd_n or bus_wr_n = 0 for T_STROBE cycles.
    - RD: bus_din is sampled on the last STROBE cycle.
  - HOLD: cs/rd/wr = 1 for T_HOLD cycles.
    - WR: bus_doe stays 1 throughout HOLD.
    - RD: rdata/rdata_valid are presented in the first HOLD cycle.
    - At the end of HOLD: if word counter ≠ 0, decrement, advance the address and go to SETUP. Otherwise go to IDLE with done = 1.
- done and req_ready are high in the same cycle; a new request may be accepted in that cycle.
- Reset mid-request: the bus is released at the next edge, the request is dropped and no done is issued.

## Timing
- Accept at cycle 0.
- Per word: T_SETUP + T_STROBE + T_HOLD cycles, plus any wdata stall.
- Single read: rdata_valid in cycle 1+T_SETUP+T_STROBE; done in cycle 1+T_SETUP+T_STROBE+T_HOLD.
- Burst of N words: done in cycle 1+N·(T_SETUP+T_STROBE+T_HOLD), with no stalls.
- bus_addr is stable from the first SETUP cycle through the last HOLD cycle of each word.
- bus_dout is stable from capture through HOLD.

## Configuration
- W5300_REQ_CHECK_EN defined:
  - A request is rejected at accept if any of the following holds: req_addr[0] = 1; sock_reg = 1 and req_sock >= SOCKETS; sock_reg = 1 and req_addr is outside 0x200..0x23E.
  - A rejected request produces no bus activity and done = err = 1 in cycle 1.
- Undefined: no checks; err is tied to 0.

## Test plan
- Write MR 0x000 = 0xB800, len 0, with the default parameters:
  - bus_addr = 0x000; bus_cs_n low cycles 1–8; bus_wr_n low cycles 2–8; bus_dout = 0xB800 with bus_doe high cycles 1–10.
  - done in cycle 11.
- Read IDR 0x0FE with bus_din = 0x5300: rdata = 0x5300, rdata_valid in cycle 9, done in cycle 11.
- Read sock 3, addr 0x208 (Sn_SSR): bus_addr = 0x2C8. Non-socket burst at addr 0x008, len 2: bus_addr sequence 0x008, 0x00A, 0x00C; done in cycle 31.
- TX FIFO burst, sock 1, addr 0x22E, len 3, wdata 0x1111..0x4444:
  - four bus_wr_n pulses, all at bus_addr 0x26E, with data in order.
  - hold wdata_valid low for 5 cycles before word 2: cs_n stays low and wr_n stays high until the word arrives.
- Assert rst in the STROBE of word 2 of a burst: next cycle bus_cs_n = bus_rd_n = bus_wr_n = 1, bus_doe = 0, no done; req_ready = 1 after rst falls.
- With W5300_REQ_CHECK_EN and SOCKETS = 2:
  - sock 5 (or addr 0x009) gives done = err = 1 in cycle 1, with bus_cs_n never low.
  - without the macro, sock 5 drives bus_addr = 0x348.
